// File: rtl/nrs_gold_seq_ctrl.sv
// NB-IoT NRS Gold-sequence sequencer: derives c_init, warms up both 31-bit LFSRs,
// then hands out c(2m')/c(2m'+1) pairs under a valid/ready handshake.
module nrs_gold_seq_ctrl #(
    parameter int NC        = 1600,
    parameter int SKIP      = 218,
    parameter int NUM_PAIRS = 2,
    parameter int CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  ns,
    input  logic [2:0]  sym_l,
    input  logic [8:0]  cell_id,
    output logic [30:0] c_init_o,
    output logic        busy,
    output logic        c_even,
    output logic        c_odd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CINIT = 3'd1,
        LOAD  = 3'd2,
        WARM  = 3'd3,
        EMIT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int PAIR_W = $clog2(NUM_PAIRS + 1);
    localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(NC + SKIP - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NUM_PAIRS - 1);

    state_t state;
    state_t next_state;

    logic [4:0]        ns_q;
    logic [2:0]        sym_q;
    logic [8:0]        cell_q;
    logic [30:0]       x1;
    logic [30:0]       x2;
    logic [CNT_W-1:0]  warm_cnt;
    logic [PAIR_W-1:0] pair_cnt;
    logic [30:0]       sym_term;
    logic [30:0]       cell_term;
    logic [30:0]       c_init_calc;
    logic              accept;

    // Bit 0 is the oldest element; the feedback bit enters at bit 30.
    function automatic logic [30:0] step_x1(input logic [30:0] x);
        return {x[3] ^ x[0], x[30:1]};
    endfunction

    function automatic logic [30:0] step_x2(input logic [30:0] x);
        return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
    endfunction

    assign accept = (state == EMIT) && out_ready;

    // Normal-CP c_init; the largest possible value stays below 2^31.
    always_comb begin
        sym_term    = 31'd7 * (31'(ns_q) + 31'd1) + 31'(sym_q) + 31'd1;
        cell_term   = {21'd0, cell_q, 1'b1};
        c_init_calc = ((sym_term * cell_term) << 10) + cell_term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CINIT;
            CINIT:   next_state = LOAD;
            LOAD:    next_state = WARM;
            WARM:    if (warm_cnt == WARM_LAST) next_state = EMIT;
            EMIT:    if (accept && (pair_cnt == PAIR_LAST)) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // c_odd is c after one step, which is simply the next-oldest bit of each register.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        c_even    = 1'b0;
        c_odd     = 1'b0;
        unique case (state)
            CINIT, LOAD, WARM: busy = 1'b1;
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                c_even    = x1[0] ^ x2[0];
                c_odd     = x1[1] ^ x2[1];
            end
            FIN:     done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_q     <= '0;
            sym_q    <= '0;
            cell_q   <= '0;
            c_init_o <= '0;
            x1       <= '0;
            x2       <= '0;
            warm_cnt <= '0;
            pair_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ns_q   <= ns;
                        sym_q  <= sym_l;
                        cell_q <= cell_id;
                    end
                end
                CINIT: c_init_o <= c_init_calc;
                LOAD: begin
                    x1       <= 31'h1;
                    x2       <= c_init_o;
                    warm_cnt <= '0;
                    pair_cnt <= '0;
                end
                WARM: begin
                    x1       <= step_x1(x1);
                    x2       <= step_x2(x2);
                    warm_cnt <= warm_cnt + 1'b1;
                end
                EMIT: begin
                    if (accept) begin
                        x1       <= step_x1(step_x1(x1));
                        x2       <= step_x2(step_x2(x2));
                        pair_cnt <= pair_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
